// File: rtl/adder_pkg.sv
// Shared types and sizing for the adder operand loader.
// Lane 0 of an operand vector is the least significant word.
package adder_pkg;

    localparam int LANES = 4;
    localparam int WIDTH = 32;
    localparam int IDX_W = $clog2(LANES);

    // Cycles after a launch during which adder ready is not trusted
    localparam logic [1:0] GUARD_CYCLES = 2'd2;

    typedef logic [LANES-1:0][WIDTH-1:0] operand_vec_t;

    typedef enum logic [1:0] {
        FILL_A,
        FILL_B,
        FULL
    } fill_state_t;

    typedef enum logic {
        IDLE,
        BUSY
    } launch_state_t;

endpackage

// File: rtl/operand_stager.sv
// Packs the serial word stream into staging A/B vectors.
// Holds a complete set until the launch logic consumes it.
module operand_stager
    import adder_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_ci,
    input  logic               consume,
    output logic               full,
    output operand_vec_t       stage_a,
    output operand_vec_t       stage_b,
    output logic               stage_ci
);

    fill_state_t        fill_q;
    logic [IDX_W-1:0]   idx_q;
    operand_vec_t       a_q;
    operand_vec_t       b_q;
    logic               ci_q;
    logic               take;
    logic               last;

    assign in_ready = reset_n && (fill_q != FULL);
    assign take     = in_valid && in_ready;
    assign last     = (idx_q == IDX_W'(LANES - 1));
    assign full     = (fill_q == FULL);
    assign stage_a  = a_q;
    assign stage_b  = b_q;
    assign stage_ci = ci_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= FILL_A;
            idx_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ci_q   <= 1'b0;
        end else begin
            unique case (fill_q)
                FILL_A: if (take) begin
                    a_q[idx_q] <= in_data;
                    if (idx_q == '0) ci_q <= in_ci;
                    if (last) begin
                        fill_q <= FILL_B;
                        idx_q  <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                FILL_B: if (take) begin
                    b_q[idx_q] <= in_data;
                    if (last) begin
                        fill_q <= FULL;
                        idx_q  <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                FULL: if (consume) begin
                    fill_q <= FILL_A;
                    idx_q  <= '0;
                end
                default: fill_q <= FILL_A;
            endcase
        end
    end

endmodule

// File: rtl/adder_operand_loader.sv
// Launches the 4-lane adder from double-buffered staged operands.
// Outputs stay frozen from start until the next launch.
module adder_operand_loader
    import adder_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_ci,
    output operand_vec_t       numberA,
    output operand_vec_t       numberB,
    output logic               ci,
    output logic               start,
    input  logic               adder_ready,
    output logic               busy,
    output logic [15:0]        launch_count
);

    launch_state_t  launch_q;
    logic [1:0]     guard_q;
    operand_vec_t   a_q;
    operand_vec_t   b_q;
    logic           ci_q;
    logic           start_q;
    logic [15:0]    launch_count_q;
    logic           full;
    logic           launch;
    operand_vec_t   stage_a;
    operand_vec_t   stage_b;
    logic           stage_ci;

    assign launch = full && (launch_q == IDLE);

    operand_stager u_stager (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ci    (in_ci),
        .consume  (launch),
        .full     (full),
        .stage_a  (stage_a),
        .stage_b  (stage_b),
        .stage_ci (stage_ci)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            launch_q       <= IDLE;
            guard_q        <= '0;
            a_q            <= '0;
            b_q            <= '0;
            ci_q           <= 1'b0;
            start_q        <= 1'b0;
            launch_count_q <= '0;
        end else begin
            start_q <= launch;
            if (launch) begin
                a_q            <= stage_a;
                b_q            <= stage_b;
                ci_q           <= stage_ci;
                launch_q       <= BUSY;
                guard_q        <= GUARD_CYCLES;
                launch_count_q <= launch_count_q + 16'd1;
            end else if (launch_q == BUSY) begin
                // Ready may still reflect the previous result right after start
                if (guard_q != '0) begin
                    guard_q <= guard_q - 2'd1;
                end else if (adder_ready) begin
                    launch_q <= IDLE;
                end
            end
        end
    end

    assign numberA      = a_q;
    assign numberB      = b_q;
    assign ci           = ci_q;
    assign start        = start_q;
    assign busy         = (launch_q == BUSY);
    assign launch_count = launch_count_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Randomised and directed bench for adder_operand_loader.
// A set-level model predicts every output on every cycle.
module tb_adder_operand_loader;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ci = 1'b0;
    logic         adder_ready = 1'b0;
    logic         in_ready;
    logic [127:0] numberA;
    logic [127:0] numberB;
    logic         ci;
    logic         start;
    logic         busy;
    logic [15:0]  launch_count;

    adder_operand_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_ci        (in_ci),
        .numberA      (numberA),
        .numberB      (numberB),
        .ci           (ci),
        .start        (start),
        .adder_ready  (adder_ready),
        .busy         (busy),
        .launch_count (launch_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit rnd = 0;
    bit preload_req = 0;

    // Model: words collected for the set in progress, and what the adder sees
    int          m_cnt;
    logic [31:0] m_w [8];
    logic        m_sci;
    bit          m_busy;
    int          m_age;
    logic [15:0] m_lc;
    logic [31:0] m_a [4];
    logic [31:0] m_b [4];
    logic        m_ci;
    logic        m_start;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0; m_sci = 0; m_busy = 0; m_age = 0;
            m_lc = 0; m_ci = 0; m_start = 0;
            for (int i = 0; i < 8; i++) m_w[i] = 0;
            for (int i = 0; i < 4; i++) begin m_a[i] = 0; m_b[i] = 0; end
        end else begin
            bit full_now;
            bit go;
            full_now = (m_cnt == 8);
            go = full_now && !m_busy;
            m_start = 0;
            if (m_busy) begin
                if (m_age >= 2 && adder_ready) m_busy = 0;
                m_age++;
            end
            if (go) begin
                for (int i = 0; i < 4; i++) begin
                    m_a[i] = m_w[i];
                    m_b[i] = m_w[4 + i];
                end
                m_ci = m_sci;
                m_cnt = 0;
                m_start = 1;
                m_busy = 1;
                m_age = 0;
                m_lc = m_lc + 16'd1;
            end else if (in_valid && !full_now) begin
                m_w[m_cnt] = in_data;
                if (m_cnt == 0) m_sci = in_ci;
                m_cnt++;
            end
            if (preload_req) m_lc = 16'hFFFE;
        end
    end

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cmp_cycle();
        logic [127:0] ea;
        logic [127:0] eb;
        for (int i = 0; i < 4; i++) begin
            ea[i*32 +: 32] = m_a[i];
            eb[i*32 +: 32] = m_b[i];
        end
        check("in_ready", in_ready, reset_n && (m_cnt < 8));
        check("start", start, m_start);
        check("busy", busy, m_busy);
        check("ci", ci, m_ci);
        check("numberA", numberA, ea);
        check("numberB", numberB, eb);
        if (!preload_req) check("launch_count", launch_count, m_lc);
    endtask

    task automatic tick();
        if (rnd) adder_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; tick(); end
    endtask

    task automatic send(input logic [31:0] d, input logic c);
        bit ok = 0;
        in_data = d;
        in_ci = c;
        in_valid = 1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tick();
        end
        in_valid = 0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_start(output int k);
        k = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            k++;
            if (start) return;
        end
        check("start_timeout", 0, 1);
        k = -1;
    endtask

    logic [31:0] s1 [8] = '{32'h04002001, 32'h02005001, 32'h00600041,
                            32'h00000001, 32'h06000031, 32'h20508001,
                            32'h002104C0, 32'h00011001};
    logic [31:0] s2 [8] = '{32'h11111111, 32'h22222222, 32'h33333333,
                            32'h44444444, 32'hAAAAAAAA, 32'hBBBBBBBB,
                            32'hCCCCCCCC, 32'hDDDDDDDD};
    localparam logic [127:0] S1A = {32'h00000001, 32'h00600041,
                                    32'h02005001, 32'h04002001};
    localparam logic [127:0] S1B = {32'h00011001, 32'h002104C0,
                                    32'h20508001, 32'h06000031};
    localparam logic [127:0] S2A = {32'h44444444, 32'h33333333,
                                    32'h22222222, 32'h11111111};
    localparam logic [127:0] S2B = {32'hDDDDDDDD, 32'hCCCCCCCC,
                                    32'hBBBBBBBB, 32'hAAAAAAAA};

    initial begin
        int k;
        fork
            forever begin @(negedge clk); cmp_cycle(); end
        join_none

        // Reset
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_numberA", numberA, 0);
        check("rst_count", launch_count, 0);
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // First set, continuous stream
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(s1[i], 1'b0);
        wait_start(k);
        check("start_latency", k, 2);
        check("set1_A", numberA, S1A);
        check("set1_B", numberB, S1B);
        check("set1_ci", ci, 0);

        // Second set fills while busy and is held
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(s2[i], 1'b0);
        @(negedge clk);
        check("held_in_ready", in_ready, 0);
        check("held_A", numberA, S1A);
        idle(4);
        adder_ready = 1;
        wait_start(k);
        check("ready_to_start", k, 3);
        check("set2_A", numberA, S2A);
        check("set2_B", numberB, S2B);
        k = 0;
        for (int i = 0; i < 20 && busy; i++) begin @(negedge clk); k++; end
        check("busy_fall", k, 3);

        // Gapped stream with carry-in
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            send(s1[i], i == 0);
            idle(1);
        end
        wait_start(k);
        check("gap_A", numberA, S1A);
        check("gap_B", numberB, S1B);
        check("gap_ci", ci, 1);

        // Reset mid-set discards the partial set
        idle(5);
        for (int i = 0; i < 5; i++) send(s2[i], 1'b1);
        reset_n = 0;
        @(negedge clk);
        check("mid_rst_A", numberA, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", launch_count, 0);
        check("mid_rst_ready", in_ready, 0);
        @(posedge clk); #1 reset_n = 1;
        for (int i = 0; i < 8; i++) send(s1[i], 1'b0);
        wait_start(k);
        check("post_rst_latency", k, 2);
        check("post_rst_A", numberA, S1A);
        check("post_rst_B", numberB, S1B);
        check("post_rst_count", launch_count, 1);

        // Counter wrap via preload
        idle(6);
        @(posedge clk); #2;
        force dut.launch_count_q = 16'hFFFE;
        preload_req = 1;
        @(posedge clk); #2;
        release dut.launch_count_q;
        preload_req = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(s2[i], 1'b0);
        wait_start(k);
        check("count_ffff", launch_count, 16'hFFFF);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(s1[i], 1'b0);
        wait_start(k);
        check("count_wrap", launch_count, 16'h0000);

        // Random traffic
        rnd = 1;
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < 8; i++) begin
                send($urandom, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rnd = 0;
        adder_ready = 1;
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_operand_loader.md
# adder_operand_loader

Upstream feeder for the 4-lane parallel 32-bit adder: accepts a serial stream of 32-bit words over a valid/ready handshake, packs them into a staging buffer as operand vectors A and B, then launches the adder by presenting `numberA`/`numberB`/`ci` together with a one-cycle `start` pulse. Staging is double-buffered: the next operand set fills while the adder works on the current one. The loader waits for the adder's `ready` before launching again.

## Interface
- `LANES`, 4, number of adder lanes
- `WIDTH`, 32, bits per lane word

- `clk`  in  1  single clock, all logic rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  loader accepts word this cycle
- `in_data`  in  WIDTH  operand word
- `in_ci`  in  1  carry-in, sampled with the first A word of a set
- `numberA`  out  LANES×WIDTH  packed operand A to adder, lane 0 = [0]
- `numberB`  out  LANES×WIDTH  packed operand B to adder
- `ci`  out  1  carry-in to adder
- `start`  out  1  one-cycle launch pulse, drives the adder's `reset` (start) input
- `adder_ready`  in  1  adder's `ready`, result valid
- `busy`  out  1  an adder operation is outstanding
- `launch_count`  out  16  number of launches since reset, wraps 0xFFFF→0

## Operation
- Word order per set: A lane0..lane(LANES-1), then B lane0..lane(LANES-1), i.e. 2·LANES words. A word transfers when `in_valid && in_ready`.
- Fill FSM (`FILL_A`, `FILL_B`, `FULL`): a lane index counter 0..LANES-1 writes into the staging A/B registers. The last A word moves to `FILL_B`, and the index resets to 0. The last B word moves to `FULL`. `in_ready` = 1 in `FILL_A`/`FILL_B` and 0 in `FULL`.
- Launch FSM (`IDLE`, `BUSY`): the launch condition is fill=`FULL` and launch=`IDLE`.
  - On launch, the staging A/B/ci copy into the output registers, `start` is set for one cycle, `launch_count` increments, the launch FSM moves to `BUSY`, and the fill FSM moves to `FILL_A` with index 0.
- In `BUSY`, `adder_ready` is ignored in the `start` cycle and the following cycle, then sampled. When sampled high, the launch FSM moves to `IDLE`.
- `busy` = (launch state == `BUSY`).
- `numberA`/`numberB`/`ci` are held stable from the `start` cycle until the next launch. They are never modified while `BUSY`.
- No arithmetic on data. Words are copied bit-exact.

## Timing
- Reset values: `numberA`=0, `numberB`=0, `ci`=0, `start`=0, `busy`=0, `launch_count`=0, `in_ready`=0 while `reset_n` is low.
- After reset the state is `FILL_A`/`IDLE`, and `in_ready`=1 in the first cycle after `reset_n` rises.
- Last B word accepted in cycle T: `FULL` in T+1. If `IDLE`, the launch occurs at the end of T+1. `start`, new operands, and `busy`=1 become visible in T+2, and `in_ready`=1 again in T+2.
- While `BUSY`, the next set fills. If it reaches `FULL`, `in_ready` drops and the set is held.
- `adder_ready` sampled high in cycle R gives `IDLE` in R+1. A pending `FULL` set then produces `start` visible in R+2.
- Minimum `start` spacing is 4 cycles.
- `in_valid` low mid-set stalls filling with no data loss, and the index holds.
- Reset asserted mid-operation clears staging, the index, both FSMs, and all outputs immediately. A partial set is discarded.

## Structure
- Package `adder_pkg` contains:
  - `LANES`, `WIDTH`
  - `typedef logic [LANES-1:0][WIDTH-1:0] operand_vec_t`
  - enums `fill_state_t` and `launch_state_t`
- Sub-module `operand_stager` holds the fill FSM, lane index, and staging A/B/ci registers. It exposes `full` and accepts a `consume` input from the launch logic.
- The top level holds the launch FSM, the output registers, the ready-guard counter, and `launch_count`.

## Test plan
- Stream A={0x04002001,0x02005001,0x00600041,0x00000001} then B={0x06000031,0x20508001,0x002104C0,0x00011001}, `in_ci`=0, continuous valid → `start` visible 2 cycles after the 8th word, with `numberA`/`numberB` lanes matching and `ci`=0.
- Hold `adder_ready`=1 constantly → it is ignored for 2 cycles after `start`, `busy` falls on the 3rd cycle, and there is no double launch.
- Send a second set during `BUSY` → `in_ready` drops after the 8th word, outputs stay unchanged until `adder_ready`, and the next `start` occurs 2 cycles after `adder_ready`.
- Toggle `in_valid` every other cycle with `in_ci`=1 on the first word → identical packed result, `ci`=1.
- Pull `reset_n` low after 5 words → all outputs are 0 and the next 8 words form a fresh set starting at A lane0.
- Run 65537 launches (or preload) → `launch_count` wraps 0xFFFF→0x0000.
